// File: rtl/sw_tile_sched.sv
`default_nettype none
// =============================================================================
// Module   : sw_tile_sched
// Purpose  : Sequences sw_array over a job of N tiles (prefetch, start, drain)
//            and captures every array result word into an output FIFO.
//            Optional ping-pong buffering: define SW_SCHED_DOUBLE_BUF_EN.
// Revision : 1.0 - initial release
// =============================================================================
module sw_tile_sched #(
  parameter int CACHE_WIDTH = 512,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [15:0]            cfg_num_tiles,
  input  logic [15:0]            cfg_max_weight_addr,
  input  logic [31:0]            cfg_img_base,
  input  logic [31:0]            cfg_img_stride,
  output logic                   pf_req,
  output logic [31:0]            pf_addr,
  output logic                   pf_buf_sel,
  input  logic                   pf_done,
  output logic                   arr_start,
  output logic [15:0]            arr_max_weight_addr,
  output logic                   arr_buf_sel,
  input  logic                   arr_valid,
  input  logic [CACHE_WIDTH-1:0] arr_result,
  input  logic                   arr_filters_finished,
  input  logic                   arr_pipeline_empty,
  output logic                   res_valid,
  output logic [CACHE_WIDTH-1:0] res_data,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err_overflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tile_idx_q, tile_idx_d;
  logic [15:0] num_tiles_q, num_tiles_d;
  logic [31:0] stride_q, stride_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [15:0] mwa_q, mwa_d;
  logic        pf_req_q, pf_req_d;
  logic [31:0] pf_addr_q, pf_addr_d;
  logic        pf_buf_sel_q, pf_buf_sel_d;
  logic        arr_buf_sel_q, arr_buf_sel_d;
  logic        prefetched_q, prefetched_d;
  logic        cfg_ready_q, busy_q, done_q, arr_start_q;
  logic        last_tile;

  always_comb begin
    state_d       = state_q;
    tile_idx_d    = tile_idx_q;
    num_tiles_d   = num_tiles_q;
    stride_d      = stride_q;
    cur_addr_d    = cur_addr_q;
    mwa_d         = mwa_q;
    pf_req_d      = pf_req_q;
    pf_addr_d     = pf_addr_q;
    pf_buf_sel_d  = pf_buf_sel_q;
    arr_buf_sel_d = arr_buf_sel_q;
    prefetched_d  = prefetched_q;
    last_tile     = (tile_idx_q == num_tiles_q - 16'd1);

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          num_tiles_d   = cfg_num_tiles;
          stride_d      = cfg_img_stride;
          mwa_d         = cfg_max_weight_addr;
          cur_addr_d    = cfg_img_base;
          tile_idx_d    = 16'd0;
          arr_buf_sel_d = 1'b0;
          prefetched_d  = 1'b0;
          if (cfg_num_tiles == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_LOAD;
            pf_req_d     = 1'b1;
            pf_addr_d    = cfg_img_base;
            pf_buf_sel_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (pf_done) begin
          pf_req_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
`ifdef SW_SCHED_DOUBLE_BUF_EN
        // Overlap the next tile's load with this tile's compute.
        if (!last_tile) begin
          pf_req_d     = 1'b1;
          pf_addr_d    = cur_addr_q + stride_q;
          pf_buf_sel_d = ~arr_buf_sel_q;
        end
`endif
      end
      S_RUN: begin
`ifdef SW_SCHED_DOUBLE_BUF_EN
        if (pf_req_q && pf_done) begin
          pf_req_d     = 1'b0;
          prefetched_d = 1'b1;
        end
`endif
        if (arr_filters_finished) state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef SW_SCHED_DOUBLE_BUF_EN
        if (pf_req_q && pf_done) begin
          pf_req_d     = 1'b0;
          prefetched_d = 1'b1;
        end
`endif
        if (!arr_filters_finished && arr_pipeline_empty) state_d = S_NEXT;
      end
      S_NEXT: begin
        tile_idx_d = tile_idx_q + 16'd1;
        cur_addr_d = cur_addr_q + stride_q;
`ifdef SW_SCHED_DOUBLE_BUF_EN
        arr_buf_sel_d = ~arr_buf_sel_q;
`endif
        if (last_tile) begin
          state_d = S_DONE;
        end else if (prefetched_q) begin
          // Tile already resident: the LOAD wait collapses to nothing.
          prefetched_d = 1'b0;
          state_d      = S_START;
        end else begin
          state_d = S_LOAD;
          if (!pf_req_q) begin
            pf_req_d     = 1'b1;
            pf_addr_d    = cur_addr_d;
            pf_buf_sel_d = arr_buf_sel_d;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tile_idx_q    <= 16'd0;
      num_tiles_q   <= 16'd0;
      stride_q      <= 32'd0;
      cur_addr_q    <= 32'd0;
      mwa_q         <= 16'd0;
      pf_req_q      <= 1'b0;
      pf_addr_q     <= 32'd0;
      pf_buf_sel_q  <= 1'b0;
      arr_buf_sel_q <= 1'b0;
      prefetched_q  <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      arr_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tile_idx_q    <= tile_idx_d;
      num_tiles_q   <= num_tiles_d;
      stride_q      <= stride_d;
      cur_addr_q    <= cur_addr_d;
      mwa_q         <= mwa_d;
      pf_req_q      <= pf_req_d;
      pf_addr_q     <= pf_addr_d;
      pf_buf_sel_q  <= pf_buf_sel_d;
      arr_buf_sel_q <= arr_buf_sel_d;
      prefetched_q  <= prefetched_d;
      cfg_ready_q   <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      arr_start_q   <= (state_d == S_START);
    end
  end

  assign cfg_ready           = cfg_ready_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign arr_start           = arr_start_q;
  assign pf_req              = pf_req_q;
  assign pf_addr             = pf_addr_q;
  assign pf_buf_sel          = pf_buf_sel_q;
  assign arr_buf_sel         = arr_buf_sel_q;
  assign arr_max_weight_addr = mwa_q;

  // Result FIFO: extra pointer bit distinguishes full from empty.
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   err_q, err_d;
  logic                   fifo_empty, fifo_full, push, pop, ovf;
  logic [CACHE_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && res_ready;
    push       = arr_valid && (!fifo_full || pop);
    ovf        = arr_valid && fifo_full && !pop;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    err_d      = ovf ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= arr_result;
  end

  assign res_valid    = !fifo_empty;
  assign res_data     = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign err_overflow = err_q;

endmodule
`default_nettype wire
